// File: rtl/bin_to_7seg_scan.sv
// Sequential binary-to-digit converter (double-dabble / octal / hex slicing) driving
// one shared active-low 7-segment bus through a free-running anode scan.
//
// state  | meaning
// S_IDLE | waiting for start, display holds last result
// S_CONV | IN_WIDTH fixed-latency conversion steps
// S_LOAD | commit glyphs and overflow to the display, pulse done
module bin_to_7seg_scan #(
    parameter int IN_WIDTH   = 16,
    parameter int NUM_DIGITS = 5,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   value,
    input  logic [1:0]            radix,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n
);
    localparam int DEC_D = ((IN_WIDTH + 2) / 3 > NUM_DIGITS) ? (IN_WIDTH + 2) / 3 : NUM_DIGITS;
    localparam int BCD_W = 4 * DEC_D;
    localparam int XW    = IN_WIDTH + 4 * NUM_DIGITS;
    localparam int CW    = $clog2(IN_WIDTH);
    localparam int SW    = $clog2(SCAN_DIV);
    localparam int IW    = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} t_state;

    t_state                       r_state;
    t_state                       w_state_nxt;
    logic                         w_capture;
    logic                         w_step;
    logic                         w_load;
    logic                         w_busy_nxt;

    logic [CW-1:0]                r_cnt;
    logic [BCD_W-1:0]             r_bcd;
    logic [BCD_W-1:0]             w_bcd_adj;
    logic [IN_WIDTH-1:0]          r_bin;
    logic [IN_WIDTH-1:0]          r_val;
    logic [1:0]                   r_radix;
    logic                         r_blank_lz;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_ovf;
    logic                         w_ovf;
    logic [XW-1:0]                w_valx;
    logic [NUM_DIGITS-1:0][6:0]   r_disp;
    logic [NUM_DIGITS-1:0][6:0]   w_glyph;

    logic [SW-1:0]                r_scan_cnt;
    logic [IW-1:0]                r_idx;
    logic [NUM_DIGITS-1:0]        r_an_n;
    logic [6:0]                   r_seg_n;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'h0: f_glyph = 7'b0000001;
            4'h1: f_glyph = 7'b1001111;
            4'h2: f_glyph = 7'b0010010;
            4'h3: f_glyph = 7'b0000110;
            4'h4: f_glyph = 7'b1001100;
            4'h5: f_glyph = 7'b0100100;
            4'h6: f_glyph = 7'b0100000;
            4'h7: f_glyph = 7'b0001111;
            4'h8: f_glyph = 7'b0000000;
            4'h9: f_glyph = 7'b0000100;
            4'hA: f_glyph = 7'b0001000;
            4'hB: f_glyph = 7'b1100000;
            4'hC: f_glyph = 7'b0110001;
            4'hD: f_glyph = 7'b1000010;
            4'hE: f_glyph = 7'b0110000;
            default: f_glyph = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CONV;
            S_CONV:  if (r_cnt == '0) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture  = (r_state == S_IDLE) && start;
        w_step     = (r_state == S_CONV);
        w_load     = (r_state == S_LOAD);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Add-3 correction applied to every BCD nibble before each shift
    for (genvar g = 0; g < DEC_D; g++) begin : g_adj
        assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                                : r_bcd[4*g +: 4];
    end

    assign w_valx = XW'(r_val);

    always_comb begin
        w_ovf = 1'b0;
        case (r_radix)
            2'b01:   w_ovf = (w_valx >> (3 * NUM_DIGITS)) != '0;
            2'b10:   w_ovf = (w_valx >> (4 * NUM_DIGITS)) != '0;
            default: w_ovf = (r_bcd >> (4 * NUM_DIGITS)) != '0;
        endcase
    end

    // Walk from the top digit down so "any nonzero digit at or above" is known per digit
    always_comb begin
        logic [3:0] l_dig;
        logic       l_nz;
        l_dig   = 4'd0;
        l_nz    = 1'b0;
        w_glyph = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            case (r_radix)
                2'b01:   l_dig = {1'b0, w_valx[3*i +: 3]};
                2'b10:   l_dig = w_valx[4*i +: 4];
                default: l_dig = r_bcd[4*i +: 4];
            endcase
            l_nz = l_nz | (l_dig != 4'd0);
            if (w_ovf)                          w_glyph[i] = 7'b1111110;
            else if (r_blank_lz && i != 0 && !l_nz) w_glyph[i] = 7'b1111111;
            else                                w_glyph[i] = f_glyph(l_dig);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_val      <= '0;
            r_radix    <= 2'b00;
            r_blank_lz <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_disp     <= '1;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_load;
            if (w_capture) begin
                r_cnt      <= CW'(IN_WIDTH - 1);
                r_bcd      <= '0;
                r_bin      <= value;
                r_val      <= value;
                r_radix    <= radix;
                r_blank_lz <= blank_lz;
            end else if (w_step) begin
                r_cnt          <= r_cnt - CW'(1);
                {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
            end
            if (w_load) begin
                r_ovf  <= w_ovf;
                r_disp <= w_glyph;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an_n     <= '1;
            r_seg_n    <= 7'h7F;
        end else begin
            if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SW'(1);
            end
            r_an_n  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg_n <= r_disp[r_idx];
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_ovf;
    assign seg_n    = r_seg_n;
    assign an_n     = r_an_n;
endmodule
